// File: rtl/mem_access_unit.sv
// Memory access sequencer: turns multi-cycle controller commands into a req/ack
// transaction, latches IR/MDR, reports sticky errors. Optional: MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              ir_write,
    input  logic              iord,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic              m_req,
    output logic              m_we,
    output logic [DATA_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mdr,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ERR_HOLD
    } state_t;

    localparam logic [1:0] ERR_CONFLICT = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    localparam logic [1:0] ERR_MISALIGN = 2'b11;
`endif
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic              rd_prev_q, wr_prev_q;
    logic [7:0]        wait_q, wait_d;
    logic              load_ir_q, load_ir_d;
    logic              m_req_q, m_req_d;
    logic              busy_q, busy_d;
    logic              m_we_q, m_we_d;
    logic [DATA_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              trigger;
    logic [DATA_W-1:0] sel_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rd_prev_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            wait_q     <= '0;
            load_ir_q  <= 1'b0;
            m_req_q    <= 1'b0;
            busy_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            instr_q    <= '0;
            mdr_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            rd_prev_q  <= mem_read;
            wr_prev_q  <= mem_write;
            wait_q     <= wait_d;
            load_ir_q  <= load_ir_d;
            m_req_q    <= m_req_d;
            busy_q     <= busy_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            instr_q    <= instr_d;
            mdr_q      <= mdr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Only a fresh 0->1 of either command starts an access; held levels do not.
    always_comb begin
        trigger  = (mem_read & ~rd_prev_q) | (mem_write & ~wr_prev_q);
        sel_addr = iord ? alu_out : pc;
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        load_ir_d  = load_ir_q;
        m_req_d    = m_req_q;
        busy_d     = busy_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        instr_d    = instr_q;
        mdr_d      = mdr_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        unique case (state_q)
            IDLE, ERR_HOLD: begin
                if (trigger) begin
                    if (mem_read && mem_write) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CONFLICT;
                        state_d    = ERR_HOLD;
                    end
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                    else if (sel_addr[1:0] != 2'b00) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_MISALIGN;
                        state_d    = ERR_HOLD;
                    end
`endif
                    else begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        m_addr_d = sel_addr;
`else
                        m_addr_d = sel_addr & {{(DATA_W-2){1'b1}}, 2'b00};
`endif
                        m_we_d    = mem_write;
                        m_wdata_d = wdata;
                        load_ir_d = ir_write;
                        m_req_d   = 1'b1;
                        busy_d    = 1'b1;
                        wait_d    = '0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (m_ack) begin
                    if (!m_we_q) begin
                        mdr_d = m_rdata;
                        if (load_ir_q) begin
                            instr_d = m_rdata;
                        end
                    end
                    m_req_d = 1'b0;
                    busy_d  = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    m_req_d    = 1'b0;
                    busy_d     = 1'b0;
                    m_we_d     = 1'b0;
                    state_d    = ERR_HOLD;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_req    = m_req_q;
    assign busy     = busy_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign instr    = instr_q;
    assign mdr      = mdr_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
